// File: rtl/gate_bist.sv
// Built-in self test for a 2-input gate: walks {a,b} through 00..11, holds each
// vector SETTLE+1 cycles, and compares the sampled response against EXPECT.
module gate_bist #(
  parameter int unsigned SETTLE = 2,
  parameter logic [3:0]  EXPECT = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] fail_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;

  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [3:0]  cnt_q;
  logic        a_q, b_q, busy_q, done_q, pass_q;
  logic [3:0]  fail_vec_q, fail_vec_d;
  logic [2:0]  fail_count_q, fail_count_d;
  logic        sample, mismatch;

  // Response is judged on the last edge of each hold window; the updated
  // result is also what pass is derived from when the final vector lands.
  always_comb begin
    sample       = (state_q == DRIVE) && (cnt_q == SettleCnt);
    mismatch     = sample && (y != EXPECT[idx_q]);
    fail_vec_d   = fail_vec_q;
    fail_count_d = fail_count_q;
    if (mismatch) begin
      fail_vec_d   = fail_vec_q | (4'b0001 << idx_q);
      fail_count_d = fail_count_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 4'd0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_vec_q   <= 4'd0;
      fail_count_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= DRIVE;
            idx_q        <= 2'd0;
            cnt_q        <= 4'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_vec_q   <= 4'd0;
            fail_count_q <= 3'd0;
          end
        end
        DRIVE: begin
          fail_vec_q   <= fail_vec_d;
          fail_count_q <= fail_count_d;
          if (sample) begin
            cnt_q <= 4'd0;
            if (idx_q != 2'd3) begin
              idx_q        <= idx_q + 2'd1;
              {a_q, b_q}   <= idx_q + 2'd1;
            end else begin
              state_q <= DONE;
              idx_q   <= 2'd0;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_vec_d == 4'd0);
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          a_q     <= 1'b0;
          b_q     <= 1'b0;
        end
      endcase
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_vec   = fail_vec_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: a NOR-expecting instance (SETTLE=2) and an AND-expecting
// instance (SETTLE=0), each driving a truth-table model of the gate under test.
module tb_gate_bist;

  localparam logic [3:0] Expect0 = 4'b0001;
  localparam logic [3:0] Expect1 = 4'b1000;
  localparam int         Settle0 = 2;
  localparam int         Settle1 = 0;

  logic       clk;
  logic       rst_n;
  logic       start0, start1;
  logic       a0, b0, y0, busy0, done0, pass0;
  logic       a1, b1, y1, busy1, done1, pass1;
  logic [3:0] failVec0, failVec1;
  logic [2:0] failCount0, failCount1;
  logic [3:0] tbl0, tbl1;

  int checks = 0;
  int passes = 0;
  logic [1:0] trace [64];
  int traceLen;
  int busyLow;

  assign y0 = tbl0[{a0, b0}];
  assign y1 = tbl1[{a1, b1}];

  gate_bist #(.SETTLE(Settle0), .EXPECT(Expect0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_vec(failVec0), .fail_count(failCount0)
  );

  gate_bist #(.SETTLE(Settle1), .EXPECT(Expect1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_vec(failVec1), .fail_count(failCount1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start on the chosen instance, records the vector trace while the run
  // is in progress and returns the cycle count until done (-1 on timeout).
  task automatic runSeq(input bit sel, input bit pulses, output int lat);
    lat = -1;
    traceLen = 0;
    busyLow = 0;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int c = 0; c <= 100; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (sel ? done1 : done0) begin
        lat = c;
        break;
      end
      if (!(sel ? busy1 : busy0)) busyLow++;
      if (traceLen < 64) begin
        trace[traceLen] = sel ? {a1, b1} : {a0, b0};
        traceLen++;
      end
      if (pulses) begin
        if (sel) start1 = 1'($urandom_range(0, 1));
        else     start0 = 1'($urandom_range(0, 1));
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({a0, b0, busy0, done0, pass0} !== 5'b0) $display("[TB] FAIL reset_ctrl0: got %b expected 00000", {a0, b0, busy0, done0, pass0}); else passes++;
    checks++; if ({failVec0, failCount0} !== 7'b0) $display("[TB] FAIL reset_res0: got %b expected 0", {failVec0, failCount0}); else passes++;
    checks++; if ({a1, b1, busy1, done1, pass1, failVec1, failCount1} !== 12'b0) $display("[TB] FAIL reset_all1: got %b expected 0", {a1, b1, busy1, done1, pass1, failVec1, failCount1}); else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_nor();
    int lat;
    int bad;
    tbl0 = 4'b0001;
    runSeq(1'b0, 1'b0, lat);
    checks++; if (lat !== 4 * (Settle0 + 1)) $display("[TB] FAIL nor_latency: got %0d expected %0d", lat, 4 * (Settle0 + 1)); else passes++;
    bad = 0;
    for (int j = 0; j < traceLen; j++)
      if (trace[j] !== 2'(j / (Settle0 + 1))) bad++;
    checks++; if (bad != 0 || traceLen != 12 || busyLow != 0) $display("[TB] FAIL nor_trace: got %0d bad vectors, len %0d, busyLow %0d expected 0, 12, 0", bad, traceLen, busyLow); else passes++;
    checks++; if ({pass0, failVec0, failCount0} !== {1'b1, 4'b0, 3'd0}) $display("[TB] FAIL nor_result: got %b expected 10000000", {pass0, failVec0, failCount0}); else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({done0, busy0, a0, b0, pass0} !== 5'b10001) $display("[TB] FAIL nor_done_hold: got %b expected 10001", {done0, busy0, a0, b0, pass0}); else passes++;
  endtask

  task automatic test_faults();
    int lat;
    logic [3:0] tbls [3];
    logic [3:0] expVec;
    tbls[0] = 4'b0000;
    tbls[1] = 4'b1111;
    tbls[2] = 4'b1110;
    for (int t = 0; t < 3; t++) begin
      tbl0 = tbls[t];
      runSeq(1'b0, 1'b0, lat);
      expVec = tbl0 ^ Expect0;
      checks++; if ({failVec0, failCount0, pass0} !== {expVec, 3'($countones(expVec)), 1'b0}) $display("[TB] FAIL fault_tbl%0d: got vec %b cnt %0d pass %b expected vec %b cnt %0d pass 0", t, failVec0, failCount0, pass0, expVec, $countones(expVec)); else passes++;
      checks++; if (lat !== 12) $display("[TB] FAIL fault_latency%0d: got %0d expected 12", t, lat); else passes++;
    end
  endtask

  task automatic test_rerun();
    int lat;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    checks++; if ({busy0, done0, pass0, failVec0, failCount0} !== {1'b1, 1'b0, 1'b0, 4'b0, 3'd0}) $display("[TB] FAIL rerun_clear: got %b expected 1000000000", {busy0, done0, pass0, failVec0, failCount0}); else passes++;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done0) begin
        lat = c;
        break;
      end
    end
    checks++; if (lat !== 12 || failVec0 !== 4'b1111) $display("[TB] FAIL rerun_result: got lat %0d vec %b expected lat 12 vec 1111", lat, failVec0); else passes++;
  endtask

  task automatic test_reset_mid();
    int lat;
    tbl0 = 4'b0001;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++; if ({a0, b0} !== 2'b10) $display("[TB] FAIL mid_vector: got %b expected 10", {a0, b0}); else passes++;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({a0, b0, busy0, done0, pass0, failVec0, failCount0} !== 12'b0) $display("[TB] FAIL mid_async_clear: got %b expected 0", {a0, b0, busy0, done0, pass0, failVec0, failCount0}); else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy0, done0} !== 2'b00) $display("[TB] FAIL mid_idle_wait: got %b expected 00", {busy0, done0}); else passes++;
    runSeq(1'b0, 1'b0, lat);
    checks++; if (lat !== 12 || pass0 !== 1'b1) $display("[TB] FAIL mid_restart: got lat %0d pass %b expected lat 12 pass 1", lat, pass0); else passes++;
  endtask

  task automatic test_back_to_back();
    int bad;
    int doneCycles;
    logic expDone;
    doReset();
    tbl0 = 4'b0001;
    start0 = 1'b1;
    @(posedge clk); #1;
    bad = 0;
    doneCycles = 0;
    for (int j = 0; j < 40; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      expDone = (j >= 12) && ((j - 12) % 13 == 0);
      if (done0 !== expDone) bad++;
      if (done0 === 1'b1) doneCycles++;
    end
    start0 = 1'b0;
    checks++; if (bad != 0 || doneCycles != 3) $display("[TB] FAIL b2b_done_pattern: got %0d wrong cycles, %0d done cycles expected 0, 3", bad, doneCycles); else passes++;
    doReset();
  endtask

  task automatic test_random();
    int lat;
    bit pulses;
    logic [3:0] expVec;
    for (int it = 0; it < 10; it++) begin
      tbl0 = 4'($urandom);
      pulses = 1'($urandom_range(0, 1));
      runSeq(1'b0, pulses, lat);
      expVec = tbl0 ^ Expect0;
      checks++; if (lat !== 12) $display("[TB] FAIL rand_latency%0d: got %0d expected 12", it, lat); else passes++;
      checks++; if ({failVec0, failCount0, pass0} !== {expVec, 3'($countones(expVec)), expVec == 4'b0}) $display("[TB] FAIL rand_result%0d: got vec %b cnt %0d pass %b expected vec %b cnt %0d", it, failVec0, failCount0, pass0, expVec, $countones(expVec)); else passes++;
    end
  endtask

  task automatic test_settle0();
    int lat;
    int bad;
    logic [3:0] expVec;
    tbl1 = 4'b1000;
    runSeq(1'b1, 1'b0, lat);
    checks++; if (lat !== 4 || pass1 !== 1'b1 || failVec1 !== 4'b0) $display("[TB] FAIL s0_and: got lat %0d pass %b vec %b expected lat 4 pass 1 vec 0000", lat, pass1, failVec1); else passes++;
    bad = 0;
    for (int j = 0; j < traceLen; j++)
      if (trace[j] !== 2'(j)) bad++;
    checks++; if (bad != 0 || traceLen != 4) $display("[TB] FAIL s0_trace: got %0d bad, len %0d expected 0, 4", bad, traceLen); else passes++;
    for (int it = 0; it < 4; it++) begin
      tbl1 = 4'($urandom);
      runSeq(1'b1, 1'b1, lat);
      expVec = tbl1 ^ Expect1;
      checks++; if (lat !== 4 || {failVec1, failCount1, pass1} !== {expVec, 3'($countones(expVec)), expVec == 4'b0}) $display("[TB] FAIL s0_rand%0d: got lat %0d vec %b cnt %0d expected lat 4 vec %b", it, lat, failVec1, failCount1, expVec); else passes++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    tbl0   = 4'b0001;
    tbl1   = 4'b1000;
    test_reset();
    test_nor();
    test_faults();
    test_rerun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_settle0();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
